slave_reg_bank: RTL and testbench

// - Downstream slave for the 3-master arbiter: consumes valid_slaveN/addr_out/value_out, returns ready.
// - Buffers accepted writes in a DEPTH-entry FIFO.
// - Commits them one at a time into an 8 x 3-bit register bank through a slow write engine.
// - One instance per slave (slave1, slave2). The bank has a registered read port for downstream consumers.

---
 rtl/slave_reg_bank.sv | 144 ++++++++++++++
 tb/tb_slave_reg_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_reg_bank.sv
// Arbiter-facing slave: DEPTH-entry write FIFO draining through a slow write engine into an 8 x 3-bit bank.
// Optional macro ACC_MODE_EN turns the overwrite commit into a saturating 3-bit accumulate.
module slave_reg_bank #(
  parameter int DEPTH  = 4,
  parameter int WR_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [2:0]               addr_in,
  input  logic [2:0]               value_in,
  output logic                     ready_out,
  input  logic [2:0]               rd_addr,
  output logic [2:0]               rd_data,
  output logic                     wr_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

  typedef struct packed {
    logic [2:0] addr;
    logic [2:0] value;
  } entry_t;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  entry_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  state_t             state;
  state_t             state_next;
  logic [LAT_W-1:0]   cnt;
  logic [LAT_W-1:0]   cnt_next;
  entry_t             hold;

  logic [2:0]         bank [8];
  logic [2:0]         commit_value;

  logic               push;
  logic               pop;
  logic               commit;

  // Full is judged on the registered count alone, so a same-cycle pop never frees a slot for a push.
  assign ready_out  = (count != CNT_W'(DEPTH));
  assign push       = valid_in && ready_out;
  assign fill_level = count;
  assign busy       = (state != IDLE) || (count != '0);

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{addr: addr_in, value: value_in};
    end
  end

  // NOTE: sequential state is always updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          cnt_next   = LAT_W'(WR_LAT - 1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - LAT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hold    <= '0;
      wr_done <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      wr_done <= commit;
      if (pop) hold <= fifo_mem[rd_ptr];
    end
  end

`ifdef ACC_MODE_EN
  logic [3:0] acc_sum;

  always_comb begin
    acc_sum      = {1'b0, bank[hold.addr]} + {1'b0, hold.value};
    commit_value = acc_sum[3] ? 3'd7 : acc_sum[2:0];
  end
`else
  assign commit_value = hold.value;
`endif

  // Read samples the pre-edge bank, so a same-edge commit shows up one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= bank[rd_addr];
      if (commit) bank[hold.addr] <= commit_value;
    end
  end

endmodule

// File: tb/tb_slave_reg_bank.sv
// Self-checking bench for slave_reg_bank: directed vector table, corner sequences and random traffic vs a queue model.
module tb_slave_reg_bank;

  localparam int DEPTH  = 4;
  localparam int WR_LAT = 2;
`ifdef ACC_MODE_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [2:0] addr_in;
  logic [2:0] value_in;
  logic       ready_out;
  logic [2:0] rd_addr;
  logic [2:0] rd_data;
  logic       wr_done;
  logic       busy;
  logic [$clog2(DEPTH):0] fill_level;

  slave_reg_bank #(.DEPTH(DEPTH), .WR_LAT(WR_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .addr_in    (addr_in),
    .value_in   (value_in),
    .ready_out  (ready_out),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_done    (wr_done),
    .busy       (busy),
    .fill_level (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending writes in a queue, an engine that commits WR_LAT edges after taking the head.
  typedef struct {
    int addr;
    int value;
  } wr_t;

  wr_t m_q[$];
  int  m_bank[8];
  bit  m_active;
  int  m_rem;
  wr_t m_hold;
  int  m_rd;
  bit  m_wd;
  bit  m_push;

  typedef struct {
    bit valid;
    int addr;
    int value;
    int rd;
    bit exp_ready;
    int exp_fill;
    bit exp_wd;
    int exp_rd;
  } vec_t;

  vec_t vecs[5];

  function automatic int commit_of(int old_v, int v);
    if (ACC) return (old_v + v > 7) ? 7 : old_v + v;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 8; i++) m_bank[i] = 0;
    m_active = 1'b0;
    m_rem    = 0;
    m_rd     = 0;
    m_wd     = 1'b0;
    m_push   = 1'b0;
  endtask

  task automatic model_edge(input bit v, input int a, input int d, input int ra);
    wr_t e;
    m_rd   = m_bank[ra];
    m_wd   = 1'b0;
    m_push = v && (m_q.size() != DEPTH);
    if (m_active) begin
      m_rem--;
      if (m_rem == 0) begin
        m_bank[m_hold.addr] = commit_of(m_bank[m_hold.addr], m_hold.value);
        m_wd     = 1'b1;
        m_active = 1'b0;
      end
    end else if (m_q.size() != 0) begin
      m_hold   = m_q.pop_front();
      m_active = 1'b1;
      m_rem    = WR_LAT;
    end
    if (m_push) begin
      e.addr  = a;
      e.value = d;
      m_q.push_back(e);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_ready"}, int'(ready_out), int'(m_q.size() != DEPTH));
    check({tag, "_fill"},  int'(fill_level), m_q.size());
    check({tag, "_wrdone"}, int'(wr_done), int'(m_wd));
    check({tag, "_rddata"}, int'(rd_data), m_rd);
    check({tag, "_busy"},  int'(busy), int'(m_active || m_q.size() != 0));
  endtask

  task automatic step(input bit v, input int a, input int d, input int ra, input string tag);
    valid_in = v;
    addr_in  = 3'(a);
    value_in = 3'(d);
    rd_addr  = 3'(ra);
    @(posedge clk);
    model_edge(v, a, d, ra);
    #1;
    compare_all(tag);
  endtask

  // Asserted away from a clock edge; outputs must clear without waiting for one.
  task automatic do_reset(input string tag);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    check({tag, "_rst_ready"}, int'(ready_out), 1);
    check({tag, "_rst_fill"}, int'(fill_level), 0);
    check({tag, "_rst_rddata"}, int'(rd_data), 0);
    check({tag, "_rst_wrdone"}, int'(wr_done), 0);
    check({tag, "_rst_busy"}, int'(busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_commit(input int ra, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 0, 0, ra, tag);
      seen = m_wd;
    end
    check({tag, "_commit_seen"}, int'(wr_done), 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    addr_in  = '0;
    value_in = '0;
    rd_addr  = '0;
    model_reset();
    #12;
    do_reset("init");

    // Single write addr=5 val=3: commit edge, then readback one cycle later.
    vecs[0] = '{1'b1, 5, 3, 5, 1'b1, 1, 1'b0, 0};
    vecs[1] = '{1'b0, 5, 3, 5, 1'b1, 0, 1'b0, 0};
    vecs[2] = '{1'b0, 0, 0, 5, 1'b1, 0, 1'b0, 0};
    vecs[3] = '{1'b0, 0, 0, 5, 1'b1, 0, 1'b1, 0};
    vecs[4] = '{1'b0, 0, 0, 5, 1'b1, 0, 1'b0, 3};
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].valid, vecs[i].addr, vecs[i].value, vecs[i].rd, "vec");
      check($sformatf("vec%0d_ready", i), int'(ready_out), int'(vecs[i].exp_ready));
      check($sformatf("vec%0d_fill", i), int'(fill_level), vecs[i].exp_fill);
      check($sformatf("vec%0d_wrdone", i), int'(wr_done), int'(vecs[i].exp_wd));
      check($sformatf("vec%0d_rddata", i), int'(rd_data), vecs[i].exp_rd);
    end

    // Backpressure: six writes to addr 0..5, data held until accepted.
    do_reset("fill");
    begin
      int k = 0;
      bit saw_full = 1'b0;
      for (int c = 0; c < 60 && k < 6; c++) begin
        step(1'b1, k, (k + 2) % 8, 0, "fill");
        if (m_push) k++;
        if (!ready_out) saw_full = 1'b1;
      end
      check("fill_all_accepted", k, 6);
      check("fill_saw_full", int'(saw_full), 1);
      for (int c = 0; c < 60 && (m_q.size() != 0 || m_active); c++) step(1'b0, 0, 0, 0, "drain");
      for (int a = 0; a < 6; a++) begin
        step(1'b0, 0, 0, a, "fill_rd");
        step(1'b0, 0, 0, a, "fill_rd");
        check($sformatf("fill_reg%0d", a), int'(rd_data), (a + 2) % 8);
      end
    end

    // Full with a same-edge pop: the push is refused, then taken one edge later.
    do_reset("fullpop");
    begin
      bit found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
        if (m_q.size() == DEPTH && !m_active) found = 1'b1;
        else step(1'b1, c % 8, c % 8, 0, "fullpop_pre");
      end
      check("fullpop_reached", int'(found), 1);
      step(1'b1, 7, 7, 0, "fullpop_edge");
      check("fullpop_refused_fill", int'(fill_level), DEPTH - 1);
      step(1'b1, 7, 7, 0, "fullpop_next");
      check("fullpop_accept_fill", int'(fill_level), DEPTH);
    end

    // Read/commit collision on reg2: old 1 seen on the commit edge, new value next cycle.
    do_reset("coll");
    step(1'b1, 2, 1, 2, "coll_w1");
    wait_commit(2, "coll_w1");
    step(1'b1, 2, 6, 2, "coll_w2");
    wait_commit(2, "coll_w2");
    check("coll_old", int'(rd_data), 1);
    step(1'b0, 0, 0, 2, "coll_after");
    check("coll_new", int'(rd_data), ACC ? 7 : 6);

    // reg7 written with 5 then 4.
    do_reset("acc");
    step(1'b1, 7, 5, 7, "acc_w1");
    wait_commit(7, "acc_w1");
    step(1'b0, 0, 0, 7, "acc_r1");
    check("acc_first", int'(rd_data), 5);
    step(1'b1, 7, 4, 7, "acc_w2");
    wait_commit(7, "acc_w2");
    step(1'b0, 0, 0, 7, "acc_r2");
    check("acc_second", int'(rd_data), ACC ? 7 : 4);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), "rand");
    end

    // Reset with writes pending: nothing may commit afterwards, and the bank reads back zero.
    for (int c = 0; c < 3; c++) step(1'b1, c + 1, 5, 0, "mid_pre");
    do_reset("mid");
    for (int a = 0; a < 8; a++) begin
      step(1'b0, 0, 0, a, "mid_rd");
      check($sformatf("mid_reg%0d_zero", a), int'(rd_data), 0);
      check($sformatf("mid_nodone%0d", a), int'(wr_done), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
